// File: rtl/strip_check_crc.sv
// RX-side FCS checker: runs CRC-32 over each frame including its FCS, holds back
// the last 4 bytes as FCS candidates and forwards only payload with a bad-frame flag.
module strip_check_crc #(
   parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
   input  logic       clock,
   input  logic       aresetn,
   input  logic [7:0] saxis_tdata,
   input  logic       saxis_tvalid,
   output logic       saxis_tready,
   input  logic       saxis_tlast,
   input  logic       saxis_tuser,
   output logic [7:0] maxis_tdata,
   output logic       maxis_tvalid,
   input  logic       maxis_tready,
   output logic       maxis_tlast,
   output logic       maxis_tuser,
   output logic       frame_ok,
   output logic       frame_bad,
   output logic       runt
);

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int unsigned i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   logic [31:0] r_crc;
   logic [2:0]  r_fill;
   logic        r_err;
   logic [7:0]  r_win [4];
   logic [7:0]  r_m_data;
   logic        r_m_valid;
   logic        r_m_last;
   logic        r_m_user;
   logic        r_ok;
   logic        r_bad;
   logic        r_runt;

   logic        w_win_full;
   logic        w_accept;
   logic [31:0] w_next_crc;
   logic        w_bad;

   assign w_win_full   = (r_fill == 3'd4);
   assign saxis_tready = !w_win_full || !r_m_valid || maxis_tready;
   assign w_accept     = saxis_tvalid && saxis_tready;
   assign w_next_crc   = crc32_byte(r_crc, saxis_tdata);
   assign w_bad        = (w_next_crc != RESIDUE) || r_err || saxis_tuser;

   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         r_crc     <= '1;
         r_fill    <= '0;
         r_err     <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) r_win[i] <= '0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
         r_m_user  <= 1'b0;
         r_ok      <= 1'b0;
         r_bad     <= 1'b0;
         r_runt    <= 1'b0;
      end else begin
         r_ok   <= 1'b0;
         r_bad  <= 1'b0;
         r_runt <= 1'b0;
         if (r_m_valid && maxis_tready)
            r_m_valid <= 1'b0;
         if (w_accept) begin
            // Window always shifts toward index 0, so r_win[0] is the oldest byte once full.
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= r_win[3];
            r_win[3] <= saxis_tdata;
            if (w_win_full) begin
               r_m_valid <= 1'b1;
               r_m_data  <= r_win[0];
               r_m_last  <= saxis_tlast;
               r_m_user  <= saxis_tlast && w_bad;
            end
            if (saxis_tlast) begin
               r_crc  <= '1;
               r_fill <= '0;
               r_err  <= 1'b0;
               if (w_win_full) begin
                  r_ok  <= !w_bad;
                  r_bad <= w_bad;
               end else begin
                  r_runt <= 1'b1;
               end
            end else begin
               r_crc <= w_next_crc;
               if (!w_win_full)
                  r_fill <= r_fill + 3'd1;
               if (saxis_tuser)
                  r_err <= 1'b1;
            end
         end
      end
   end

   assign maxis_tdata  = r_m_data;
   assign maxis_tvalid = r_m_valid;
   assign maxis_tlast  = r_m_last;
   assign maxis_tuser  = r_m_user;
   assign frame_ok     = r_ok;
   assign frame_bad    = r_bad;
   assign runt         = r_runt;

endmodule

// File: tb/tb_strip_check_crc.sv
// Directed bench for strip_check_crc: known CRC vectors, runts, input errors,
// throughput, random backpressure and mid-frame reset, scored against an expected-beat queue.
module tb_strip_check_crc;

   logic       clock = 1'b0;
   logic       aresetn = 1'b0;
   logic [7:0] saxis_tdata = '0;
   logic       saxis_tvalid = 1'b0;
   logic       saxis_tready;
   logic       saxis_tlast = 1'b0;
   logic       saxis_tuser = 1'b0;
   logic [7:0] maxis_tdata;
   logic       maxis_tvalid;
   logic       maxis_tready = 1'b1;
   logic       maxis_tlast;
   logic       maxis_tuser;
   logic       frame_ok;
   logic       frame_bad;
   logic       runt;

   strip_check_crc #(.RESIDUE(32'hDEBB20E3)) dut (
      .clock        (clock),
      .aresetn      (aresetn),
      .saxis_tdata  (saxis_tdata),
      .saxis_tvalid (saxis_tvalid),
      .saxis_tready (saxis_tready),
      .saxis_tlast  (saxis_tlast),
      .saxis_tuser  (saxis_tuser),
      .maxis_tdata  (maxis_tdata),
      .maxis_tvalid (maxis_tvalid),
      .maxis_tready (maxis_tready),
      .maxis_tlast  (maxis_tlast),
      .maxis_tuser  (maxis_tuser),
      .frame_ok     (frame_ok),
      .frame_bad    (frame_bad),
      .runt         (runt)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   int    n_checks = 0;
   int    n_errors = 0;
   beat_t exp_q[$];
   beat_t mon_e;
   logic [7:0] frm[$];
   int    cyc = 0;
   bit    sb_on = 1'b1;
   bit    tp_mode = 1'b0;
   bit    rnd_ready = 1'b0;
   bit    in_frame = 1'b0;
   int    first_cyc = 0;
   int    nb = 0;
   int    ok_cnt = 0, bad_cnt = 0, runt_cnt = 0;
   int    e_ok = 0, e_bad = 0, e_runt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clock) cyc++;

   always @(posedge clock) begin
      #1;
      maxis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Pulses are counted per cycle high, so a stretched pulse shows up as an extra count.
   always @(negedge clock) begin
      if (frame_ok)  ok_cnt++;
      if (frame_bad) bad_cnt++;
      if (runt)      runt_cnt++;
      if (aresetn && sb_on && maxis_tvalid && maxis_tready) begin
         chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("tdata", 32'(maxis_tdata), 32'(mon_e.d));
            chk("tlast", 32'(maxis_tlast), 32'(mon_e.l));
            chk("tuser", 32'(maxis_tuser), 32'(mon_e.u));
         end
         if (!in_frame) begin
            first_cyc = cyc;
            nb = 0;
            in_frame = 1'b1;
         end
         nb++;
         if (maxis_tlast) begin
            in_frame = 1'b0;
            if (tp_mode) chk("throughput_span", 32'(cyc - first_cyc), 32'(nb - 1));
         end
      end
   end

   function automatic logic [31:0] crc_ref();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (frm[i]) begin
         c = c ^ {24'h0, frm[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic mk_good(input int len);
      logic [31:0] f;
      frm.delete();
      for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
      f = crc_ref();
      frm.push_back(f[7:0]);
      frm.push_back(f[15:8]);
      frm.push_back(f[23:16]);
      frm.push_back(f[31:24]);
   endtask

   task automatic mk_check_vec();
      frm.delete();
      for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
      frm.push_back(8'h26);
      frm.push_back(8'h39);
      frm.push_back(8'hF4);
      frm.push_back(8'hCB);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l, input logic u);
      int k;
      bit acc;
      k = 0;
      acc = 1'b0;
      saxis_tdata  = b;
      saxis_tlast  = l;
      saxis_tuser  = u;
      saxis_tvalid = 1'b1;
      while (!acc && k < 2000) begin
         @(negedge clock);
         acc = saxis_tready;
         @(posedge clock);
         #1;
         k++;
      end
      if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
      saxis_tvalid = 1'b0;
      saxis_tlast  = 1'b0;
      saxis_tuser  = 1'b0;
   endtask

   task automatic send_frame(input int err_idx, input bit exp_bad, input bit gaps);
      int n;
      n = frm.size();
      if (n > 4)
         for (int i = 0; i < n - 4; i++)
            exp_q.push_back('{d: frm[i], l: (i == n - 5), u: (i == n - 5) && exp_bad});
      for (int i = 0; i < n; i++) begin
         send_byte(frm[i], i == n - 1, i == err_idx);
         if (gaps && i != n - 1 && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
         end
      end
      chk("frame_ok_pulse",  32'(frame_ok),  32'(n > 4 && !exp_bad));
      chk("frame_bad_pulse", 32'(frame_bad), 32'(n > 4 && exp_bad));
      chk("runt_pulse",      32'(runt),      32'(n <= 4));
      if (n <= 4) e_runt++;
      else if (exp_bad) e_bad++;
      else e_ok++;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 20000) begin
         @(posedge clock);
         #1;
         k++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_ok_cnt"},   32'(ok_cnt),   32'(e_ok));
      chk({tag, "_bad_cnt"},  32'(bad_cnt),  32'(e_bad));
      chk({tag, "_runt_cnt"}, 32'(runt_cnt), 32'(e_runt));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tvalid"},    32'(maxis_tvalid), 32'd0);
      chk({tag, "_tdata"},     32'(maxis_tdata),  32'd0);
      chk({tag, "_tlast"},     32'(maxis_tlast),  32'd0);
      chk({tag, "_tuser"},     32'(maxis_tuser),  32'd0);
      chk({tag, "_frame_ok"},  32'(frame_ok),     32'd0);
      chk({tag, "_frame_bad"}, 32'(frame_bad),    32'd0);
      chk({tag, "_runt"},      32'(runt),         32'd0);
      chk({tag, "_s_tready"},  32'(saxis_tready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      aresetn = 1'b1;
      @(posedge clock);
      #1;

      // "123456789" with its FCS: CRC-32 = CBF43926, sent LSB first.
      mk_check_vec();
      send_frame(-1, 1'b0, 1'b0);
      drain();
      check_counts("good");

      mk_check_vec();
      frm[4] = 8'h36;
      send_frame(-1, 1'b1, 1'b0);
      drain();
      check_counts("corrupt");

      mk_check_vec();
      send_frame(2, 1'b1, 1'b0);
      drain();
      check_counts("in_err");

      frm.delete();
      frm.push_back(8'hAA); frm.push_back(8'hBB); frm.push_back(8'hCC);
      send_frame(-1, 1'b0, 1'b0);
      frm.delete();
      frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03); frm.push_back(8'h04);
      send_frame(-1, 1'b0, 1'b0);
      mk_good(64);
      send_frame(-1, 1'b0, 1'b0);
      drain();
      check_counts("runts");

      tp_mode = 1'b1;
      mk_good(64);
      send_frame(-1, 1'b0, 1'b0);
      mk_good(100);
      send_frame(-1, 1'b0, 1'b0);
      mk_good(64);
      send_frame(-1, 1'b0, 1'b0);
      drain();
      tp_mode = 1'b0;
      check_counts("thru");

      rnd_ready = 1'b1;
      for (int f = 0; f < 20; f++) begin
         mk_good(int'($urandom_range(64, 1518)));
         send_frame(-1, 1'b0, 1'b1);
      end
      drain();
      rnd_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_counts("random");

      sb_on = 1'b0;
      mk_good(40);
      for (int i = 0; i < 10; i++) send_byte(frm[i], 1'b0, 1'b0);
      #2;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      in_frame = 1'b0;
      @(posedge clock);
      #1;
      aresetn = 1'b1;
      sb_on = 1'b1;
      @(posedge clock);
      #1;
      mk_good(64);
      send_frame(-1, 1'b0, 1'b0);
      drain();
      check_counts("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
